// File: rtl/compressor_tree_pipe.sv
// Pipelined N-operand reduction tree of 4:2 compressors with valid/ready flow control.
// Define COMPRESSOR_TREE_CPA_EN to add a registered carry-propagate result_o.
module compressor_tree_pipe #(
    parameter int unsigned NUM_OPS   = 8,
    parameter int unsigned WIDTH_I   = 8,
    parameter int unsigned WIDTH_O   = WIDTH_I + $clog2(NUM_OPS),
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned SIGNED    = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [NUM_OPS-1:0][WIDTH_I-1:0] operands_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [WIDTH_O-1:0]              sum_o,
    output logic [WIDTH_O-1:0]              carry_o,
    output logic [WIDTH_O-1:0]              result_o
);
    localparam int unsigned LogP   = $clog2(NUM_OPS);
    localparam int unsigned NumPad = 1 << LogP;
    localparam int unsigned NumLvl = LogP - 1;
    localparam int unsigned NumStg = (NumLvl == 0) ? 1 : (NumLvl + REG_EVERY - 1) / REG_EVERY;

    // Operand extension and zero padding up to a power of two
    logic [NumPad-1:0][WIDTH_O-1:0] ext;

    for (genvar i = 0; i < NumPad; i++) begin : g_ext
        if (i >= NUM_OPS) begin : g_pad
            assign ext[i] = '0;
        end else if (SIGNED != 0) begin : g_sx
            assign ext[i] = WIDTH_O'($signed(operands_i[i]));
        end else begin : g_zx
            assign ext[i] = WIDTH_O'(operands_i[i]);
        end
    end

    // Stage k advances when empty or when stage k+1 advances
    logic [NumStg-1:0] valid_d, valid_q, adv, load;

    always_comb begin
        logic nxt;
        logic prev;
        nxt = out_ready_i;
        for (int k = NumStg - 1; k >= 0; k--) begin
            adv[k] = ~valid_q[k] | nxt;
            nxt    = adv[k];
        end
        prev = in_valid_i;
        for (int k = 0; k < NumStg; k++) begin
            load[k]    = adv[k] & prev;
            valid_d[k] = clear_i ? 1'b0 : (adv[k] ? prev : valid_q[k]);
            prev       = valid_q[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign in_ready_o  = adv[0] | clear_i;
    assign out_valid_o = valid_q[NumStg-1];

    for (genvar l = 0; l < NumLvl; l++) begin : g_lvl
        localparam int unsigned NumIn = NumPad >> l;
        logic [NumIn-1:0][WIDTH_O-1:0]   din;
        logic [NumIn/2-1:0][WIDTH_O-1:0] dout;

        if (l == 0) begin : g_src
            assign din = ext;
        end else if ((l % REG_EVERY) == 0) begin : g_src
            localparam int unsigned Stg = l / REG_EVERY - 1;
            logic [NumIn-1:0][WIDTH_O-1:0] pipe_d, pipe_q;

            always_comb begin
                pipe_d = pipe_q;
                if (load[Stg]) begin
                    pipe_d = g_lvl[l-1].dout;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign din = pipe_q;
        end else begin : g_src
            assign din = g_lvl[l-1].dout;
        end

        // Two chained full adders per bit; the first adder's carry feeds the next bit's cin
        for (genvar c = 0; c < NumIn / 4; c++) begin : g_c42
            logic [WIDTH_O-1:0] a, b, e, d, s1, co, ci;
            assign a  = din[4*c];
            assign b  = din[4*c+1];
            assign e  = din[4*c+2];
            assign d  = din[4*c+3];
            assign s1 = a ^ b ^ e;
            assign co = (a & b) | (a & e) | (b & e);
            assign ci = co << 1;
            assign dout[2*c]   = s1 ^ d ^ ci;
            assign dout[2*c+1] = ((s1 & d) | (s1 & ci) | (d & ci)) << 1;
        end
    end

    logic [1:0][WIDTH_O-1:0] fin;

    if (NumLvl == 0) begin : g_fin
        assign fin = ext;
    end else begin : g_fin
        assign fin = g_lvl[NumLvl-1].dout;
    end

    logic [WIDTH_O-1:0] sum_d, sum_q, carry_d, carry_q;

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        if (load[NumStg-1]) begin
            sum_d   = fin[0];
            carry_d = fin[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;

`ifdef COMPRESSOR_TREE_CPA_EN
    logic [WIDTH_O-1:0] result_d, result_q;

    always_comb begin
        result_d = result_q;
        if (load[NumStg-1]) begin
            result_d = fin[0] + fin[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
`else
    assign result_o = '0;
`endif

endmodule

// File: doc/compressor_tree_pipe.md
Name: compressor_tree_pipe

Overview:
- Parametrised, pipelined N-operand reduction tree built from cascaded 4:2 compression levels. Reduces NUM_OPS operands to a redundant sum/carry pair.
- Pipeline registers sit after a configurable number of levels, with valid/ready flow control.
- Serves as the partial-product and dot-product accumulation stage of the PDPU datapath, ahead of the final carry-propagate adder.

Parameters:
- NUM_OPS, 8, number of input operands (>= 2).
- WIDTH_I, 8, bit-width of each operand.
- WIDTH_O, WIDTH_I + pdpu_pkg::clog2(NUM_OPS), bit-width of the outputs.
- REG_EVERY, 1, number of 4:2 levels between pipeline registers (>= 1).
- SIGNED, 0, 1 = operands sign-extended to WIDTH_O; 0 = zero-extended.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- clear_i  input  1  synchronous flush of all pipeline stages.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  tree can accept operands this cycle.
- operands_i  input  [NUM_OPS-1:0][WIDTH_I-1:0]  operands.
- out_valid_o  output  1  sum/carry valid.
- out_ready_i  input  1  downstream accepts.
- sum_o  output  WIDTH_O  redundant sum.
- carry_o  output  WIDTH_O  redundant carry.
- result_o  output  WIDTH_O  resolved sum (see Optional Feature).

Behaviour:
- Clock/reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: all stage valid bits 0; all data registers 0. out_valid_o=0, sum_o=0, carry_o=0, result_o=0. in_ready_o=1 once reset is released.
- Operand extension: operands are extended to WIDTH_O per SIGNED. Padding to P = next power of two >= NUM_OPS uses zero operands.
- Tree shape: L = log2(P)-1 levels. Each level halves the operand count with 4:2 compressors (5:3 counter chains, cin[0]=0). All internal arithmetic is mod 2^WIDTH_O. NUM_OPS=2 gives L=0 (pass-through into the output register).
- Invariant: (sum_o + carry_o) mod 2^WIDTH_O == Σ extended operands mod 2^WIDTH_O.
- Register placement: registers follow levels REG_EVERY, 2·REG_EVERY, … (< L), plus one output register.
- Stage count: S = max(1, ceil(L/REG_EVERY)). Latency from accepted input to out_valid_o is exactly S cycles with no stalls.
- Handshake:
  - Input transfer occurs when in_valid_i & in_ready_o.
  - Output transfer occurs when out_valid_o & out_ready_i.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances when out_ready_i=1.
  - in_ready_o = stage-0 advance condition (combinational from out_ready_i through the valid chain). This sustains full throughput of 1 transfer/cycle.
- Output stability: while out_valid_o=1 and out_ready_i=0, sum_o, carry_o and result_o hold stable. No stage drops or duplicates data.
- Bubbles: empty stages do not load data. A bubble is collapsed when any later stage is stalled.
- clear_i: on the next edge, all valid bits go to 0. Data registers may retain values. An input presented in the same cycle as clear_i is discarded. in_ready_o stays 1 during clear_i.
- Reset mid-operation: all in-flight data is lost immediately. Outputs take their reset values asynchronously.
- Overflow: sums exceeding WIDTH_O wrap silently. With the default WIDTH_O this cannot occur for unsigned inputs.

Optional Feature:
- Macro: COMPRESSOR_TREE_CPA_EN.
- Defined: a WIDTH_O carry-propagate adder (sum+carry, mod 2^WIDTH_O) is placed before the output register, and result_o is registered with sum_o/carry_o. Latency is unchanged.
- Undefined: no adder is synthesised and result_o is tied to 0.

Test Plan:
- NUM_OPS=8, WIDTH_I=8, SIGNED=0, REG_EVERY=1 (S=2): all operands 8'hFF, out_ready_i=1 -> out_valid_o exactly 2 cycles later, sum_o+carry_o = 11'h7F8, result_o=11'h7F8 when the macro is defined.
- Same configuration, SIGNED=1, all operands 8'h80 -> sum_o+carry_o mod 2^11 = 11'h400 (-1024).
- Stream 16 back-to-back random vectors, toggle out_ready_i low for 3 cycles mid-stream -> in_ready_o drops, outputs hold stable while stalled, all 16 results emerge in order with no loss or duplication, reference model matches.
- NUM_OPS=5 (P=8 padding), operands 1,2,3,4,5 -> sum_o+carry_o = 15. NUM_OPS=2, REG_EVERY=3, operands 3,4 -> result 7 after 1 cycle.
- Fill the pipeline, then assert clear_i for 1 cycle with in_valid_i=1 -> out_valid_o=0 the next cycle, the cleared vector never appears, and the following input returns after S cycles.
- Assert rst_i asynchronously mid-stream between clock edges -> out_valid_o, sum_o, carry_o and result_o go to 0 immediately, and no stale data appears after release.
